// File: rtl/pipelined_divider_iter.sv
// Iterative restoring divider: one quotient bit per clock, MSB first.
// Recovers a factor from a product with valid/ready handshakes on both sides.
module pipelined_divider_iter #(
  parameter int DW = 19,
  parameter int VW = 8
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          in_valid,
  output logic          in_ready,
  input  logic [DW-1:0] dividend,
  input  logic [VW-1:0] divisor,
  output logic          out_valid,
  input  logic          out_ready,
  output logic [DW-1:0] quotient,
  output logic [VW-1:0] remainder,
  output logic          div_by_zero
);

  localparam int CW = $clog2(DW + 1);

  typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

  state_t        state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [VW:0]   r_q, r_d;          // partial remainder, one bit wider than divisor
  logic [DW-1:0] wq_q, wq_d;        // dividend bits leave at MSB, quotient bits enter at LSB
  logic [VW-1:0] dvs_q, dvs_d;
  logic          zero_q, zero_d;    // the operation in flight has a zero divisor
  logic [DW-1:0] quo_q, quo_d;
  logic [VW-1:0] rem_q, rem_d;
  logic          dbz_q, dbz_d;

  logic [VW:0]   r_shift;
  logic [VW:0]   r_sub;
  logic          q_bit;

  // One restoring step: shift in the next dividend bit, subtract if it fits
  always_comb begin
    r_shift = {r_q[VW-1:0], wq_q[DW-1]};
    q_bit   = (r_shift >= {1'b0, dvs_q});
    r_sub   = q_bit ? (r_shift - {1'b0, dvs_q}) : r_shift;
  end

  // Next-state and datapath updates; results only change on entry to DONE
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    r_d     = r_q;
    wq_d    = wq_q;
    dvs_d   = dvs_q;
    zero_d  = zero_q;
    quo_d   = quo_q;
    rem_d   = rem_q;
    dbz_d   = dbz_q;
    case (state_q)
      IDLE: begin
        if (in_valid) begin
          dvs_d   = divisor;
          wq_d    = dividend;
          r_d     = '0;
          state_d = BUSY;
          if (divisor == '0) begin
            // single dead cycle so the zero path reports one edge after accept
            zero_d = 1'b1;
            cnt_d  = CW'(1);
          end else begin
            zero_d = 1'b0;
            cnt_d  = CW'(DW);
          end
        end
      end
      BUSY: begin
        cnt_d = cnt_q - 1'b1;
        if (zero_q) begin
          if (cnt_q == CW'(1)) begin
            state_d = DONE;
            quo_d   = '1;
            rem_d   = wq_q[VW-1:0];
            dbz_d   = 1'b1;
          end
        end else begin
          r_d  = r_sub;
          wq_d = {wq_q[DW-2:0], q_bit};
          if (cnt_q == CW'(1)) begin
            state_d = DONE;
            quo_d   = {wq_q[DW-2:0], q_bit};
            rem_d   = r_sub[VW-1:0];
            dbz_d   = 1'b0;
          end
        end
      end
      DONE: begin
        if (out_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // State and datapath registers, async active-low clear
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      r_q     <= '0;
      wq_q    <= '0;
      dvs_q   <= '0;
      zero_q  <= 1'b0;
      quo_q   <= '0;
      rem_q   <= '0;
      dbz_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      r_q     <= r_d;
      wq_q    <= wq_d;
      dvs_q   <= dvs_d;
      zero_q  <= zero_d;
      quo_q   <= quo_d;
      rem_q   <= rem_d;
      dbz_q   <= dbz_d;
    end
  end

  // Handshake flags decode from registered state only
  always_comb begin
    in_ready    = (state_q == IDLE);
    out_valid   = (state_q == DONE);
    quotient    = quo_q;
    remainder   = rem_q;
    div_by_zero = dbz_q;
  end

endmodule
